udp_tx_framer: RTL and testbench

Transmit-side counterpart of the UDP/IP/Ethernet receive path. On a start request it builds a complete Ethernet II frame and emits it as a byte stream toward the MAC/PHY interface, one byte per clock-enable:
- preamble, SFD, Ethernet header, IPv4 header with computed checksum, UDP header;
- payload pulled from an upstream byte stream;
- zero pad, then CRC32 FCS.

It enforces the inter-frame gap, and sits between the application payload source and the PHY output logic.

---
 rtl/eth_types_pkg.sv | 45 ++++
 rtl/crc32_d8.sv | 21 ++
 rtl/udp_tx_framer.sv | 200 ++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
// Shared Ethernet/IPv4/UDP types and constants for the transmit and receive paths.
package eth_types_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    ETH_HEADER,
    IP_HEADER,
    UDP_HEADER,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int          MIN_FRAME_NOFCS = 60;
  localparam int          MAX_UDP_PAYLOAD = 1472;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [15:0] IP_VER_IHL_TOS  = 16'h4500;
  localparam logic [15:0] IP_FLAGS_DF     = 16'h4000;

  // Ones-complement header checksum; the checksum word itself counts as zero.
  function automatic logic [15:0] ip_checksum(
    input logic [15:0] total_len,
    input logic [15:0] id,
    input logic [7:0]  ttl,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip
  );
    logic [31:0] sum;
    sum = {16'h0, IP_VER_IHL_TOS} + {16'h0, total_len} + {16'h0, id}
        + {16'h0, IP_FLAGS_DF} + {16'h0, ttl, IP_PROTO_UDP}
        + {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]}
        + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    return ~sum[15:0];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC32 (poly 0x04C11DB7) next-state function, LSB of data first.
module crc32_d8
  import eth_types_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP transmit framer: wraps an upstream payload byte stream
// with preamble, headers, pad and FCS, then holds off for the inter-frame gap.
module udp_tx_framer
  import eth_types_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DEST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP    = 32'hC0A8_0164,
  parameter logic [31:0] DEST_IP   = 32'hC0A8_0101,
  parameter logic [15:0] SRC_PORT  = 16'd5000,
  parameter logic [15:0] DEST_PORT = 16'd5001,
  parameter logic [7:0]  TTL       = 8'd64,
  parameter int          IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_ce,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  output logic        tx_busy,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_err
);

  localparam logic [10:0] HDR_BYTES = 11'd42;
  localparam logic [10:0] MIN_NOFCS = 11'(MIN_FRAME_NOFCS);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_UDP_PAYLOAD);
  localparam logic [10:0] IFG_LAST  = 11'(IFG_BYTES - 1);

  tx_state_t   state;
  logic [10:0] cnt;
  logic [10:0] len;
  logic [15:0] ip_id;
  logic [15:0] ip_csum;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic        underrun;

  logic [15:0]  total_len;
  logic [15:0]  udp_len;
  logic [111:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;
  logic [7:0]   eth_bytes [14];
  logic [7:0]   ip_bytes  [20];
  logic [7:0]   udp_bytes [8];

  logic        start_ok;
  logic        pad_needed;
  logic [10:0] pad_last;
  logic [10:0] pay_last;
  logic        pl_take;
  logic        crc_en;
  logic        emit;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic [7:0]  cur_byte;

  assign total_len = 16'(len) + 16'd28;
  assign udp_len   = 16'(len) + 16'd8;
  assign eth_hdr   = {DEST_MAC, SRC_MAC, ETHERTYPE_IPV4};
  assign ip_hdr    = {IP_VER_IHL_TOS, total_len, ip_id, IP_FLAGS_DF,
                      TTL, IP_PROTO_UDP, ip_csum, SRC_IP, DEST_IP};
  assign udp_hdr   = {SRC_PORT, DEST_PORT, udp_len, 16'h0000};

  always_comb begin
    for (int i = 0; i < 14; i++) eth_bytes[i] = eth_hdr[8*(13-i) +: 8];
    for (int i = 0; i < 20; i++) ip_bytes[i]  = ip_hdr[8*(19-i) +: 8];
    for (int i = 0; i < 8; i++)  udp_bytes[i] = udp_hdr[8*(7-i) +: 8];
  end

  assign start_ok   = byte_ce && tx_start && (state == IDLE) && (tx_len <= MAX_LEN);
  assign pad_needed = (HDR_BYTES + len) < MIN_NOFCS;
  assign pad_last   = MIN_NOFCS - HDR_BYTES - len - 11'd1;
  assign pay_last   = len - 11'd1;

  // After an underrun the source is no longer asked for data this frame.
  assign pl_ready = byte_ce && (state == PAYLOAD) && !underrun;
  assign pl_take  = pl_ready && pl_valid;

  assign crc_en = (state == ETH_HEADER) || (state == IP_HEADER) || (state == UDP_HEADER)
               || (state == PAYLOAD) || (state == PAD);
  assign emit   = crc_en || (state == PREAMBLE) || (state == FCS);

  // An aborted frame sends the complement of the good FCS so the receiver drops it.
  assign fcs_word = underrun ? crc : ~crc;

  always_comb begin
    case (cnt[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      PREAMBLE:   cur_byte = (cnt == 11'd7) ? SFD_BYTE : PREAMBLE_BYTE;
      ETH_HEADER: cur_byte = eth_bytes[cnt[3:0]];
      IP_HEADER:  cur_byte = ip_bytes[cnt[4:0]];
      UDP_HEADER: cur_byte = udp_bytes[cnt[2:0]];
      PAYLOAD:    cur_byte = pl_take ? pl_data : 8'h00;
      FCS:        cur_byte = fcs_byte;
      default:    cur_byte = 8'h00;
    endcase
  end

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (cur_byte),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      ip_id    <= '0;
      ip_csum  <= '0;
      crc      <= '1;
      underrun <= 1'b0;
      txd      <= '0;
      tx_en    <= 1'b0;
      tx_err   <= 1'b0;
      tx_busy  <= 1'b0;
    end else if (byte_ce) begin
      txd    <= cur_byte;
      tx_en  <= emit;
      tx_err <= (state == FCS) && underrun;
      cnt    <= cnt + 11'd1;
      if (crc_en) crc <= crc_next;
      if (pl_ready && !pl_valid) underrun <= 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_ok) begin
            state    <= PREAMBLE;
            len      <= tx_len;
            tx_busy  <= 1'b1;
            crc      <= '1;
            underrun <= 1'b0;
          end
        end
        PREAMBLE: begin
          // Checksum settles long before the first IP header byte is needed.
          if (cnt == 11'd0) ip_csum <= ip_checksum(total_len, ip_id, TTL, SRC_IP, DEST_IP);
          if (cnt == 11'd7) begin
            state <= ETH_HEADER;
            cnt   <= '0;
          end
        end
        ETH_HEADER: if (cnt == 11'd13) begin
          state <= IP_HEADER;
          cnt   <= '0;
        end
        IP_HEADER: if (cnt == 11'd19) begin
          state <= UDP_HEADER;
          cnt   <= '0;
        end
        UDP_HEADER: if (cnt == 11'd7) begin
          cnt <= '0;
          if (len != 11'd0)    state <= PAYLOAD;
          else if (pad_needed) state <= PAD;
          else                 state <= FCS;
        end
        PAYLOAD: if (cnt == pay_last) begin
          cnt   <= '0;
          state <= pad_needed ? PAD : FCS;
        end
        PAD: if (cnt == pad_last) begin
          state <= FCS;
          cnt   <= '0;
        end
        FCS: if (cnt == 11'd3) begin
          state <= IFG;
          cnt   <= '0;
        end
        IFG: if (cnt == IFG_LAST) begin
          state   <= IDLE;
          cnt     <= '0;
          tx_busy <= 1'b0;
          ip_id   <= ip_id + 16'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized scoreboard bench for udp_tx_framer against a byte-level frame model.
module tb_udp_tx_framer;
  import eth_types_pkg::*;

  localparam logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] DEST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] SRC_IP    = 32'hC0A8_0164;
  localparam logic [31:0] DEST_IP   = 32'hC0A8_0101;
  localparam logic [15:0] SRC_PORT  = 16'd5000;
  localparam logic [15:0] DEST_PORT = 16'd5001;
  localparam logic [7:0]  TTL       = 8'd64;
  localparam int          IFG_BYTES = 12;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        byte_ce;
  logic        tx_start;
  logic [10:0] tx_len;
  logic        tx_busy;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  txd;
  logic        tx_en;
  logic        tx_err;

  always #5 clk = ~clk;

  udp_tx_framer #(
    .SRC_MAC(SRC_MAC), .DEST_MAC(DEST_MAC), .SRC_IP(SRC_IP), .DEST_IP(DEST_IP),
    .SRC_PORT(SRC_PORT), .DEST_PORT(DEST_PORT), .TTL(TTL), .IFG_BYTES(IFG_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .byte_ce(byte_ce), .tx_start(tx_start), .tx_len(tx_len),
    .tx_busy(tx_busy), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .txd(txd), .tx_en(tx_en), .tx_err(tx_err)
  );

  // ---------------- shared bench state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  src_q[$];
  logic [7:0]  frm[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  pay [1500];
  int          ce_div = 1;
  int          ce_phase = 0;
  int          drop_at = -1;
  int          xfer_cnt = 0;
  logic [15:0] model_id = 16'h0;
  int          exp_rx_len = 0;
  int          exp_xfers = 0;
  int          exp_err_bytes = 0;
  logic        ce_q = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic void push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endfunction

  function automatic void push_expected(input int len, input int drop, input logic [15:0] id);
    logic [31:0] sum;
    logic [31:0] c;
    logic [15:0] csum;
    logic        under;
    under = (drop >= 0) && (drop < len);
    frm.delete();
    push_be({16'h0, DEST_MAC}, 6);
    push_be({16'h0, SRC_MAC}, 6);
    push_be(64'h0800, 2);
    push_be(64'h4500, 2);
    push_be(64'(28 + len), 2);
    push_be({48'h0, id}, 2);
    push_be(64'h4000, 2);
    push_be({48'h0, TTL, 8'h11}, 2);
    push_be(64'h0, 2);
    push_be({32'h0, SRC_IP}, 4);
    push_be({32'h0, DEST_IP}, 4);
    sum = 32'h0;
    for (int i = 0; i < 10; i++) sum += {16'h0, frm[14 + 2*i], frm[15 + 2*i]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    csum = ~sum[15:0];
    frm[24] = csum[15:8];
    frm[25] = csum[7:0];
    push_be({48'h0, SRC_PORT}, 2);
    push_be({48'h0, DEST_PORT}, 2);
    push_be(64'(8 + len), 2);
    push_be(64'h0, 2);
    for (int i = 0; i < len; i++) frm.push_back((under && i >= drop) ? 8'h00 : pay[i]);
    while (frm.size() < 60) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_byte(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    foreach (frm[i]) exp_q.push_back({1'b0, frm[i]});
    for (int i = 0; i < 4; i++) exp_q.push_back(under ? {1'b1, ~c[8*i +: 8]} : {1'b0, c[8*i +: 8]});
    exp_rx_len    = frm.size() + 4;
    exp_xfers     = under ? drop : len;
    exp_err_bytes = under ? 4 : 0;
  endfunction

  // ---------------- byte strobe and payload source ----------------
  always @(posedge clk) ce_q <= byte_ce;

  initial begin
    byte_ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ce_div <= 1) byte_ce = 1'b1;
      else begin
        ce_phase = (ce_phase + 1) % ce_div;
        byte_ce  = (ce_phase == 0);
      end
    end
  end

  initial begin
    logic take;
    pl_valid = 1'b0;
    pl_data  = 8'h00;
    forever begin
      @(negedge clk);
      take = pl_ready && pl_valid;
      @(posedge clk);
      #1;
      if (take && src_q.size() > 0) begin
        void'(src_q.pop_front());
        xfer_cnt++;
      end
      if (src_q.size() > 0 && xfer_cnt != drop_at) begin
        pl_valid = 1'b1;
        pl_data  = src_q[0];
      end else begin
        pl_valid = 1'b0;
        pl_data  = 8'h00;
      end
    end
  end

  // ---------------- monitor ----------------
  int         rx_bytes = 0;
  int         err_cnt = 0;
  int         xfer_seen = 0;
  int         ifg_ce = 0;
  logic       counting_ifg = 1'b0;
  logic       prev_en = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_txd = 8'h00;

  task automatic frame_end();
    logic [31:0] sum;
    logic [31:0] c;
    check("frame_len", rx_q.size(), exp_rx_len);
    check("exp_q_drained", exp_q.size(), 0);
    check("pl_xfers", xfer_seen, exp_xfers);
    check("err_bytes", err_cnt, exp_err_bytes);
    if (rx_q.size() >= 34) begin
      sum = 32'h0;
      for (int i = 0; i < 10; i++) sum += {16'h0, rx_q[14 + 2*i], rx_q[15 + 2*i]};
      sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
      sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
      check("ip_hdr_sum", sum[15:0], 16'hFFFF);
    end
    if (exp_err_bytes == 0) begin
      c = 32'hFFFF_FFFF;
      foreach (rx_q[i]) c = crc_byte(c, rx_q[i]);
      check("fcs_residue", c, CRC32_RESIDUE);
    end
    rx_q.delete();
    rx_bytes  = 0;
    err_cnt   = 0;
    xfer_seen = 0;
  endtask

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_q.delete();
        rx_bytes     = 0;
        err_cnt      = 0;
        xfer_seen    = 0;
        counting_ifg = 1'b0;
      end else begin
        if (pl_ready) check("pl_ready_needs_ce", byte_ce, 1'b1);
        if (pl_ready && pl_valid) xfer_seen++;
        if (!ce_q && tx_busy) check("hold_between_ce", {tx_en, tx_err, txd}, {prev_en, prev_err, prev_txd});
        if (ce_q && tx_en) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", txd, $time);
          end else begin
            e = exp_q.pop_front();
            check("txd_byte", {tx_err, txd}, e);
          end
          rx_bytes++;
          if (rx_bytes > 8) rx_q.push_back(txd);
          if (tx_err) err_cnt++;
        end
        if (counting_ifg) begin
          if (ce_q) ifg_ce++;
          if (!tx_busy) begin
            check("ifg_byte_times", ifg_ce, IFG_BYTES);
            counting_ifg = 1'b0;
          end
        end
        if (prev_en && !tx_en) begin
          frame_end();
          counting_ifg = 1'b1;
          ifg_ce       = 1;
        end
      end
      prev_en  = rst ? 1'b0 : tx_en;
      prev_err = tx_err;
      prev_txd = txd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int len, input logic expect_accept);
    int guard;
    @(posedge clk);
    #2;
    tx_start = 1'b1;
    tx_len   = 11'(len);
    guard    = 0;
    forever begin
      @(posedge clk);
      guard++;
      if (byte_ce || guard > 64) break;
    end
    #2;
    tx_start = 1'b0;
    check("busy_after_start", tx_busy, expect_accept);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("idle_within_budget", tx_busy, 1'b0);
    @(negedge clk);
    #1;
  endtask

  task automatic begin_frame(input int len, input int drop, input logic fresh);
    if (fresh) for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
    push_expected(len, drop, model_id);
    src_q.delete();
    for (int i = 0; i < len; i++) src_q.push_back(pay[i]);
    xfer_cnt = 0;
    drop_at  = drop;
    start_frame(len, 1'b1);
  endtask

  task automatic end_frame(input int budget);
    wait_idle(budget);
    model_id++;
  endtask

  task automatic run_frame(input int len, input int drop, input logic fresh);
    begin_frame(len, drop, fresh);
    end_frame(4000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int len;
    int drop;
    rst      = 1'b0;
    tx_start = 1'b0;
    tx_len   = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_txd", txd, 8'h00);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_err", tx_err, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_pl_ready", pl_ready, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Empty payload: minimum frame with full pad.
    run_frame(0, -1, 1'b1);

    // Fixed payload, then a second frame to see the identification advance.
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    run_frame(4, -1, 1'b0);
    run_frame(4, -1, 1'b1);

    // Largest payload.
    run_frame(1472, -1, 1'b1);

    // Source stalls at byte 50 of 100.
    run_frame(100, 50, 1'b1);

    // Same 20-byte payload at full rate and at one strobe in ten.
    run_frame(20, -1, 1'b1);
    ce_div = 10;
    begin_frame(20, -1, 1'b0);
    repeat (200) @(posedge clk);
    #2;
    tx_start = 1'b1;
    tx_len   = 11'd5;
    repeat (40) @(posedge clk);
    #2;
    tx_start = 1'b0;
    end_frame(4000);
    start_frame(1500, 1'b0);
    repeat (300) @(posedge clk);
    #2;
    check("oversize_ignored", tx_busy, 1'b0);
    ce_div = 1;
    repeat (3) @(posedge clk);

    // Random lengths, with occasional source stalls.
    for (int k = 0; k < 6; k++) begin
      len  = int'($urandom_range(0, 80));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run_frame(len, drop, 1'b1);
    end

    // Reset in the middle of the IP header.
    begin_frame(30, -1, 1'b1);
    n = 0;
    while (rx_bytes < 26 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("reached_ip_header", rx_bytes >= 26, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("midframe_rst_tx_en", tx_en, 1'b0);
    check("midframe_rst_busy", tx_busy, 1'b0);
    exp_q.delete();
    src_q.delete();
    drop_at  = -1;
    model_id = 16'h0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    run_frame(10, -1, 1'b1);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
